// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data-memory port.
// Takes one RISC-V load/store at a time from the memory stage, checks
// funct3 legality and alignment, drives a single memory access with byte
// enables and lane-replicated write data, then returns the sign/zero
// extended result (or an error) to the pipeline.
//
// Handshake rules (both request and response channels): a transfer happens
// on a rising clock edge where valid && ready are both 1. Once valid is
// raised it stays up and its payload stays constant until that edge. ready
// may be raised or lowered freely. mem_req/mem_ack follow the same rule:
// mem_req and its address/enables/data hold until the edge where mem_ack=1.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int MEM_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  // The counter only has to reach TIMEOUT-1: the last ACCESS cycle is the
  // one where the counter already holds TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              accept;
  logic              fn_ok;
  logic              misaligned;
  logic              acc_err;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic [31:0]       lane;
  logic [31:0]       load_data;
  logic              timeout_hit;
  logic              unused_addr_hi;

  // Upper address bits lie outside the 32-word memory and are not decoded.
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  // req_ready is forced low while rst is high so nothing is accepted during
  // reset, yet the register is already 1 in the first cycle after release.
  assign req_ready  = req_ready_q & ~rst;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

  assign accept      = req_valid & req_ready;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Decode the incoming request: legality, alignment, lane enables, write data.
  always_comb begin
    fn_ok     = 1'b0;
    acc_be    = 4'b1111;
    acc_wdata = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: fn_ok = 1'b1;
      3'b100, 3'b101:         fn_ok = ~req_store;
      default:                fn_ok = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    acc_err = ~fn_ok | misaligned;
    case (req_funct3[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << req_addr[1:0];
        acc_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        acc_be    = 4'b0011 << req_addr[1:0];
        acc_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = req_wdata;
      end
    endcase
  end

  // Extract the addressed lane from the returned word and extend it.
  always_comb begin
    lane      = mem_rdata >> {off_q, 3'b000};
    load_data = lane;
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // State register plus every registered output; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next state: errors skip ACCESS, ack or timeout leave ACCESS, consume ends RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = acc_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ack || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request fields.
  always_comb begin
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          store_d     = req_store;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          cnt_d       = '0;
          if (acc_err) begin
            // Illegal or misaligned: answer with an error, never touch memory.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = req_addr[MEM_AW+1:2];
            mem_be_d    = acc_be;
            mem_wdata_d = acc_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = store_q ? 32'd0 : load_data;
          cnt_d        = '0;
        end else if (timeout_hit) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_data_d  = '0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_req_d    = 1'b0;
      end
    endcase
  end

endmodule
